sw_alloc: RTL and testbench



---
 rtl/noc_pkg.sv | 11 +
 rtl/sw_alloc_if.sv | 23 ++
 rtl/sw_alloc_rr_arb.sv | 34 +++
 rtl/sw_alloc.sv | 95 +++++++++
 tb/tb_sw_alloc.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: router-wide sizing constants, port names and credit type
package noc_pkg;
    localparam int NUM_PORTS = 5;
    localparam int NUM_VCS = 4;
    localparam int PORT_BITS = 3;
    localparam int VC_BITS = 2;
    localparam int CREDIT_BITS = 4;
    localparam int BUF_DEPTH = 8;
    typedef enum logic [PORT_BITS-1:0] {LOCAL, N, E, S, W} port_e;
    typedef logic [CREDIT_BITS-1:0] credit_t;
endpackage

// File: rtl/sw_alloc_if.sv
// sw_alloc_if: buffer/credit side handshake and crossbar controls of the switch allocator
interface sw_alloc_if;
    import noc_pkg::*;
    logic [NUM_PORTS*NUM_VCS-1:0] sa_req;
    logic [NUM_PORTS*NUM_VCS*PORT_BITS-1:0] sa_route;
    logic [NUM_PORTS*NUM_VCS*VC_BITS-1:0] sa_ovid;
    logic [NUM_PORTS-1:0] credit_ret_valid;
    logic [NUM_PORTS*VC_BITS-1:0] credit_ret_vc;
    logic [NUM_PORTS*NUM_VCS-1:0] sa_gnt;
    logic [NUM_PORTS-1:0] xbar_valid;
    logic [NUM_PORTS*PORT_BITS-1:0] xbar_sel;
    logic [NUM_PORTS*VC_BITS-1:0] xbar_ovid;
    logic [NUM_PORTS*NUM_VCS*CREDIT_BITS-1:0] out_credits;
    logic credit_err;
    modport master (
        output sa_req, sa_route, sa_ovid, credit_ret_valid, credit_ret_vc,
        input sa_gnt, xbar_valid, xbar_sel, xbar_ovid, out_credits, credit_err
    );
    modport slave (
        input sa_req, sa_route, sa_ovid, credit_ret_valid, credit_ret_vc,
        output sa_gnt, xbar_valid, xbar_sel, xbar_ovid, out_credits, credit_err
    );
endinterface

// File: rtl/sw_alloc_rr_arb.sv
// rr_arb: round-robin arbiter; search starts at a registered pointer that upd moves past the winner
module rr_arb #(
    parameter int N = 4,
    localparam int IW = N > 1 ? $clog2(N) : 1
) (
    input logic clk,
    input logic rst,
    input logic [N-1:0] req,
    input logic upd,
    output logic [N-1:0] gnt,
    output logic [IW-1:0] idx
);
    logic [IW-1:0] ptr;
    logic [IW-1:0] j;
    logic found;
    always_comb begin
        gnt = '0;
        idx = '0;
        j = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = IW'((int'(ptr) + k) % N);
            if (!found && req[j]) begin
                found = 1'b1;
                idx = j;
            end
        end
        if (found) gnt[idx] = 1'b1;
    end
    always_ff @(posedge clk) begin
        if (rst) ptr <= '0;
        else if (upd) ptr <= (int'(idx) == N - 1) ? '0 : idx + 1'b1;
    end
endmodule

// File: rtl/sw_alloc.sv
// sw_alloc: separable input-first switch allocator with per-output-VC credit tracking
module sw_alloc
    import noc_pkg::*;
(
    input logic clk,
    input logic rst,
    sw_alloc_if.slave bus
);
    localparam int NI = NUM_PORTS * NUM_VCS;
    localparam int PI = $clog2(NUM_PORTS);
    credit_t cred [NUM_PORTS][NUM_VCS];
    logic [NI-1:0] elig;
    logic [NUM_VCS-1:0] s1_gnt [NUM_PORTS];
    logic [VC_BITS-1:0] w_vc [NUM_PORTS];
    logic [PORT_BITS-1:0] w_route [NUM_PORTS];
    logic [VC_BITS-1:0] w_ovid [NUM_PORTS];
    logic [NUM_PORTS-1:0] s1_v, in_won, s2_any;
    logic [NUM_PORTS-1:0] s2_req [NUM_PORTS];
    logic [NUM_PORTS-1:0] s2_gnt [NUM_PORTS];
    logic [PI-1:0] w_port [NUM_PORTS];
    logic [NUM_VCS-1:0] dec [NUM_PORTS];
    logic [NUM_VCS-1:0] inc [NUM_PORTS];
    // Eligibility only looks at registered credits, so returns cannot reach sa_gnt this cycle
    always_comb begin
        elig = '0;
        for (int i = 0; i < NI; i++)
            elig[i] = bus.sa_req[i] && int'(bus.sa_route[i*PORT_BITS +: PORT_BITS]) < NUM_PORTS &&
                      cred[bus.sa_route[i*PORT_BITS +: PORT_BITS]][bus.sa_ovid[i*VC_BITS +: VC_BITS]] != '0;
    end
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_s1
        rr_arb #(.N(NUM_VCS)) s1 (
            .clk(clk), .rst(rst), .req(elig[p*NUM_VCS +: NUM_VCS]), .upd(in_won[p]),
            .gnt(s1_gnt[p]), .idx(w_vc[p])
        );
    end
    always_comb begin
        s1_v = '0;
        s2_any = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            s1_v[p] = |s1_gnt[p];
            w_route[p] = bus.sa_route[(p*NUM_VCS + int'(w_vc[p]))*PORT_BITS +: PORT_BITS];
            w_ovid[p] = bus.sa_ovid[(p*NUM_VCS + int'(w_vc[p]))*VC_BITS +: VC_BITS];
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            s2_req[o] = '0;
            for (int p = 0; p < NUM_PORTS; p++) s2_req[o][p] = s1_v[p] && w_route[p] == PORT_BITS'(o);
            s2_any[o] = |s2_req[o];
        end
    end
    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_s2
        rr_arb #(.N(NUM_PORTS)) s2 (
            .clk(clk), .rst(rst), .req(s2_req[o]), .upd(s2_any[o]),
            .gnt(s2_gnt[o]), .idx(w_port[o])
        );
    end
    always_comb begin
        in_won = '0;
        bus.sa_gnt = '0;
        bus.out_credits = '0;
        for (int o = 0; o < NUM_PORTS; o++)
            for (int p = 0; p < NUM_PORTS; p++) in_won[p] = in_won[p] | s2_gnt[o][p];
        for (int p = 0; p < NUM_PORTS; p++)
            for (int v = 0; v < NUM_VCS; v++) bus.sa_gnt[p*NUM_VCS + v] = in_won[p] && w_vc[p] == VC_BITS'(v);
        for (int o = 0; o < NUM_PORTS; o++)
            for (int v = 0; v < NUM_VCS; v++) begin
                dec[o][v] = s2_any[o] && w_ovid[w_port[o]] == VC_BITS'(v);
                inc[o][v] = bus.credit_ret_valid[o] && bus.credit_ret_vc[o*VC_BITS +: VC_BITS] == VC_BITS'(v);
                bus.out_credits[(o*NUM_VCS + v)*CREDIT_BITS +: CREDIT_BITS] = cred[o][v];
            end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.xbar_valid <= '0;
            bus.xbar_sel <= '0;
            bus.xbar_ovid <= '0;
            bus.credit_err <= 1'b0;
            for (int o = 0; o < NUM_PORTS; o++)
                for (int v = 0; v < NUM_VCS; v++) cred[o][v] <= credit_t'(BUF_DEPTH);
        end else begin
            bus.xbar_valid <= s2_any;
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (s2_any[o]) begin
                    bus.xbar_sel[o*PORT_BITS +: PORT_BITS] <= PORT_BITS'(w_port[o]);
                    bus.xbar_ovid[o*VC_BITS +: VC_BITS] <= w_ovid[w_port[o]];
                end
                for (int v = 0; v < NUM_VCS; v++) begin
                    if (inc[o][v] && !dec[o][v]) begin
                        if (cred[o][v] == credit_t'(BUF_DEPTH)) bus.credit_err <= 1'b1;
                        else cred[o][v] <= cred[o][v] + 1'b1;
                    end else if (dec[o][v] && !inc[o][v]) cred[o][v] <= cred[o][v] - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_sw_alloc.sv
// tb_sw_alloc: directed test-plan scenarios plus random traffic against a behavioural allocator model
module tb_sw_alloc;
    import noc_pkg::*;
    localparam int NI = NUM_PORTS * NUM_VCS;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    sw_alloc_if bus();
    sw_alloc dut (.clk(clk), .rst(rst), .bus(bus));
    int checks = 0;
    int failures = 0;
    int m_cred [NUM_PORTS][NUM_VCS];
    int m_iptr [NUM_PORTS];
    int m_optr [NUM_PORTS];
    int m_xsel [NUM_PORTS];
    int m_xov [NUM_PORTS];
    int s1w [NUM_PORTS];
    int s2w [NUM_PORTS];
    bit m_xv [NUM_PORTS];
    bit m_err;
    logic [NI-1:0] e_gnt;
    task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic int rt(int i);
        return int'(bus.sa_route[i*PORT_BITS +: PORT_BITS]);
    endfunction
    function automatic int ov(int i);
        return int'(bus.sa_ovid[i*VC_BITS +: VC_BITS]);
    endfunction
    function automatic int cr(int o, int v);
        return int'(bus.out_credits[(o*NUM_VCS + v)*CREDIT_BITS +: CREDIT_BITS]);
    endfunction
    task automatic model_reset();
        m_err = 1'b0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            m_iptr[o] = 0; m_optr[o] = 0; m_xsel[o] = 0; m_xov[o] = 0; m_xv[o] = 1'b0;
            for (int v = 0; v < NUM_VCS; v++) m_cred[o][v] = BUF_DEPTH;
        end
    endtask
    task automatic model_grant();
        e_gnt = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            s1w[p] = -1;
            for (int k = 0; k < NUM_VCS; k++) begin
                int v = (m_iptr[p] + k) % NUM_VCS;
                int i = p * NUM_VCS + v;
                if (s1w[p] < 0 && bus.sa_req[i] && rt(i) < NUM_PORTS && m_cred[rt(i)][ov(i)] > 0) s1w[p] = v;
            end
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            s2w[o] = -1;
            for (int k = 0; k < NUM_PORTS; k++) begin
                int p = (m_optr[o] + k) % NUM_PORTS;
                if (s2w[o] < 0 && s1w[p] >= 0 && rt(p*NUM_VCS + s1w[p]) == o) s2w[o] = p;
            end
            if (s2w[o] >= 0) e_gnt[s2w[o]*NUM_VCS + s1w[s2w[o]]] = 1'b1;
        end
    endtask
    task automatic model_edge();
        if (rst) begin
            model_reset();
            return;
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            int wo = (s2w[o] >= 0) ? ov(s2w[o]*NUM_VCS + s1w[s2w[o]]) : -1;
            m_xv[o] = s2w[o] >= 0;
            if (s2w[o] >= 0) begin
                m_xsel[o] = s2w[o];
                m_xov[o] = wo;
                m_iptr[s2w[o]] = (s1w[s2w[o]] + 1) % NUM_VCS;
                m_optr[o] = (s2w[o] + 1) % NUM_PORTS;
            end
            for (int v = 0; v < NUM_VCS; v++) begin
                bit d = wo == v;
                bit u = bus.credit_ret_valid[o] && int'(bus.credit_ret_vc[o*VC_BITS +: VC_BITS]) == v;
                if (u && !d) begin
                    if (m_cred[o][v] == BUF_DEPTH) m_err = 1'b1;
                    else m_cred[o][v]++;
                end else if (d && !u) m_cred[o][v]--;
            end
        end
    endtask
    task automatic tick();
        logic [NUM_PORTS-1:0] xv;
        logic [NUM_PORTS*PORT_BITS-1:0] xs;
        logic [NUM_PORTS*VC_BITS-1:0] xo;
        logic [NI*CREDIT_BITS-1:0] cv;
        @(negedge clk);
        model_grant();
        for (int o = 0; o < NUM_PORTS; o++) begin
            xv[o] = m_xv[o];
            xs[o*PORT_BITS +: PORT_BITS] = PORT_BITS'(m_xsel[o]);
            xo[o*VC_BITS +: VC_BITS] = VC_BITS'(m_xov[o]);
            for (int v = 0; v < NUM_VCS; v++) cv[(o*NUM_VCS + v)*CREDIT_BITS +: CREDIT_BITS] = CREDIT_BITS'(m_cred[o][v]);
        end
        check("gnt", bus.sa_gnt, e_gnt);
        check("xbar_valid", bus.xbar_valid, xv);
        check("xbar_sel", bus.xbar_sel, xs);
        check("xbar_ovid", bus.xbar_ovid, xo);
        check("credits", bus.out_credits, cv);
        check("credit_err", bus.credit_err, m_err);
        @(posedge clk);
        model_edge();
        #1;
    endtask
    task automatic clr();
        bus.sa_req = '0; bus.sa_route = '0; bus.sa_ovid = '0;
        bus.credit_ret_valid = '0; bus.credit_ret_vc = '0;
    endtask
    task automatic req(int i, int r, int o);
        bus.sa_req[i] = 1'b1;
        bus.sa_route[i*PORT_BITS +: PORT_BITS] = PORT_BITS'(r);
        bus.sa_ovid[i*VC_BITS +: VC_BITS] = VC_BITS'(o);
    endtask
    task automatic ret(int o, int v);
        bus.credit_ret_valid[o] = 1'b1;
        bus.credit_ret_vc[o*VC_BITS +: VC_BITS] = VC_BITS'(v);
    endtask
    task automatic do_reset();
        clr();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask
    initial begin
        int n;
        logic [NI*CREDIT_BITS-1:0] full;
        for (int i = 0; i < NI; i++) full[i*CREDIT_BITS +: CREDIT_BITS] = CREDIT_BITS'(BUF_DEPTH);
        clr();
        @(posedge clk);
        #1;
        model_reset();
        do_reset();
        check("rst_gnt", bus.sa_gnt, 0);
        check("rst_credits", bus.out_credits, full);
        check("rst_err", bus.credit_err, 0);
        // single flit: port 0 VC 0 to output E, downstream VC 1
        req(0, int'(E), 1);
        #1 check("single_gnt", bus.sa_gnt, 1);
        tick();
        clr();
        #1;
        check("single_xv", bus.xbar_valid[2], 1);
        check("single_sel", bus.xbar_sel[2*PORT_BITS +: PORT_BITS], 0);
        check("single_ovid", bus.xbar_ovid[2*VC_BITS +: VC_BITS], 1);
        check("single_cred", cr(2, 1), 7);
        tick();
        // ports 1 and 3 fight for output W
        req(4, int'(W), 0);
        req(12, int'(W), 1);
        for (int k = 0; k < 4; k++) begin
            #1 check("conflict_gnt", bus.sa_gnt, 128'(1) << ((k % 2 == 1) ? 12 : 4));
            tick();
            check("conflict_sel", bus.xbar_sel[4*PORT_BITS +: PORT_BITS], (k % 2 == 1) ? 3 : 1);
        end
        // exhaustion and single credit return
        do_reset();
        req(9, 0, 3);
        n = 0;
        repeat (12) begin
            #1 n += int'(bus.sa_gnt[9]);
            tick();
        end
        check("exhaust_count", n, 8);
        check("exhaust_idle", bus.sa_gnt, 0);
        ret(0, 3);
        #1 check("ret_same_cycle", bus.sa_gnt, 0);
        tick();
        bus.credit_ret_valid = '0;
        #1 check("ret_grant", bus.sa_gnt[9], 1);
        tick();
        check("ret_idle", bus.sa_gnt, 0);
        // grant and return on the same counter, then overflow
        bus.sa_req = '0;
        ret(0, 3);
        repeat (3) tick();
        check("pre_simul_cred", cr(0, 3), 3);
        req(9, 0, 3);
        tick();
        clr();
        #1 check("simul_cred", cr(0, 3), 3);
        ret(1, 0);
        tick();
        clr();
        #1;
        check("over_err", bus.credit_err, 1);
        check("over_cred", cr(1, 0), 8);
        repeat (3) tick();
        check("err_sticky", bus.credit_err, 1);
        // stage-1 pointer hold when the stage-1 winner loses stage 2
        do_reset();
        req(12, int'(N), 0);
        tick();
        clr();
        req(0, int'(N), 0);
        req(2, int'(E), 0);
        req(16, int'(N), 0);
        #1 check("hold_n", bus.sa_gnt, 128'(1) << 16);
        tick();
        bus.sa_req[16] = 1'b0;
        #1 check("hold_n1", bus.sa_gnt, 1);
        tick();
        // reset while credits are partly consumed
        do_reset();
        req(4, int'(S), 2);
        repeat (6) tick();
        check("pre_rst_cred", cr(3, 2), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clr();
        #1;
        check("mid_rst_cred", bus.out_credits, full);
        check("mid_rst_xv", bus.xbar_valid, 0);
        check("mid_rst_gnt", bus.sa_gnt, 0);
        // random traffic
        repeat (400) begin
            for (int i = 0; i < NI; i++) begin
                bus.sa_req[i] = $urandom_range(0, 2) != 0;
                bus.sa_route[i*PORT_BITS +: PORT_BITS] = PORT_BITS'(($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4));
                bus.sa_ovid[i*VC_BITS +: VC_BITS] = VC_BITS'($urandom_range(0, NUM_VCS - 1));
            end
            for (int o = 0; o < NUM_PORTS; o++) begin
                bus.credit_ret_valid[o] = $urandom_range(0, 2) == 0;
                bus.credit_ret_vc[o*VC_BITS +: VC_BITS] = VC_BITS'($urandom_range(0, NUM_VCS - 1));
            end
            rst = $urandom_range(0, 99) == 0;
            tick();
        end
        rst = 1'b0;
        clr();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
